// File: rtl/tone_sequencer_pkg.sv
// Shared definitions for the tone sequencer: state encoding, default widths
// and the duration value that marks the end of a song.
package tone_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_PLAY  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    localparam int DEF_NUM_NOTES = 16;
    localparam int DEF_PERIOD_W  = 12;
    localparam int DEF_DUR_W     = 20;

    // A table entry whose duration equals this value ends the song.
    localparam logic [31:0] END_MARKER_DUR = 32'd0;

endpackage

// File: rtl/tone_sequencer_note_table.sv
// Note table: NUM_NOTES entries of {half_period, duration}, one write port and
// one registered read port. A write to the address being read in the same
// cycle is forwarded into the read register, so the entry is visible on the
// read port the following cycle.
module tone_sequencer_note_table #(
    parameter int NUM_NOTES = 16,
    parameter int PERIOD_W  = 12,
    parameter int DUR_W     = 20,
    parameter int ADDR_W    = $clog2(NUM_NOTES)
) (
    input  logic                i_clk,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [PERIOD_W-1:0] i_wr_period,
    input  logic [DUR_W-1:0]    i_wr_dur,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output logic [PERIOD_W-1:0] o_rd_period,
    output logic [DUR_W-1:0]    o_rd_dur
);

    localparam int ENTRY_W = PERIOD_W + DUR_W;

    logic [ENTRY_W-1:0] r_mem [NUM_NOTES];
    logic [ENTRY_W-1:0] r_rd_data;
    logic [ENTRY_W-1:0] w_wr_data;

    assign w_wr_data = {i_wr_period, i_wr_dur};

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= w_wr_data;
        end
    end

    // Registered read with same-cycle write forwarding.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
            r_rd_data <= w_wr_data;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign {o_rd_period, o_rd_dur} = r_rd_data;

endmodule

// File: rtl/tone_sequencer.sv
// Tone sequencer: walks the note table, driving half_period/tone_en to the
// square-wave generator. Durations are counted in next_sample strobes.
// The table read address is the index the FSM will hold after this edge, so
// the read register already holds the right entry during the LOAD cycle.
module tone_sequencer
    import tone_sequencer_pkg::*;
#(
    parameter int NUM_NOTES = DEF_NUM_NOTES,
    parameter int PERIOD_W  = DEF_PERIOD_W,
    parameter int DUR_W     = DEF_DUR_W,
    parameter int LOOP      = 1,
    parameter int ADDR_W    = $clog2(NUM_NOTES)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_next_sample,
    input  logic                i_play_pause,
    input  logic                i_stop,
    input  logic                i_wr_en,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [PERIOD_W-1:0] i_wr_period,
    input  logic [DUR_W-1:0]    i_wr_dur,
    output logic [PERIOD_W-1:0] o_half_period,
    output logic                o_tone_en,
    output logic [ADDR_W-1:0]   o_note_idx,
    output logic                o_note_start,
    output logic                o_playing
);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_note_idx;
    logic [DUR_W-1:0]    r_dur_cnt;
    logic [PERIOD_W-1:0] r_half_period;
    logic                r_tone_en;
    logic                r_note_start;
    logic                r_playing;

    logic [ADDR_W-1:0]   w_idx_nxt;
    logic                w_to_idle;
    logic [PERIOD_W-1:0] w_rd_period;
    logic [DUR_W-1:0]    w_rd_dur;
    logic                w_end_marker;
    logic                w_last_idx;
    logic                w_note_done;

    assign w_end_marker = (w_rd_dur == END_MARKER_DUR[DUR_W-1:0]);
    assign w_last_idx   = (r_note_idx == ADDR_W'(NUM_NOTES - 1));
    assign w_note_done  = i_next_sample && (r_dur_cnt == DUR_W'(1));

    tone_sequencer_note_table #(
        .NUM_NOTES (NUM_NOTES),
        .PERIOD_W  (PERIOD_W),
        .DUR_W     (DUR_W),
        .ADDR_W    (ADDR_W)
    ) u_note_table (
        .i_clk       (i_clk),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_wr_period (i_wr_period),
        .i_wr_dur    (i_wr_dur),
        .i_rd_addr   (w_idx_nxt),
        .o_rd_period (w_rd_period),
        .o_rd_dur    (w_rd_dur)
    );

    // Next note index and the "return to IDLE" decision, shared by the
    // read address and the FSM so both always agree.
    always_comb begin
        w_idx_nxt = r_note_idx;
        w_to_idle = 1'b0;
        if (i_rst || i_stop) begin
            w_idx_nxt = '0;
            w_to_idle = i_stop;
        end else begin
            case (r_state)
                ST_IDLE: w_idx_nxt = '0;
                ST_LOAD: begin
                    if (w_end_marker) begin
                        w_idx_nxt = '0;
                        // An end marker at entry 0 means an empty song: stop
                        // rather than spin in LOAD forever.
                        w_to_idle = !((LOOP != 0) && (r_note_idx != '0));
                    end
                end
                ST_PLAY: begin
                    if (!i_play_pause && w_note_done) begin
                        w_idx_nxt = w_last_idx ? '0 : r_note_idx + 1'b1;
                        w_to_idle = w_last_idx && (LOOP == 0);
                    end
                end
                default: w_idx_nxt = r_note_idx;
            endcase
        end
    end

    // Sequencer FSM with registered outputs; going idle overrides any
    // transition chosen by the state case.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_note_idx    <= '0;
            r_dur_cnt     <= '0;
            r_half_period <= '0;
            r_tone_en     <= 1'b0;
            r_note_start  <= 1'b0;
            r_playing     <= 1'b0;
        end else begin
            r_note_start <= 1'b0;
            r_note_idx   <= w_idx_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (i_play_pause) begin
                        r_state   <= ST_LOAD;
                        r_playing <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // Outputs hold the previous note here so there is no
                    // gap in the tone between consecutive notes.
                    if (!w_end_marker) begin
                        r_half_period <= w_rd_period;
                        r_dur_cnt     <= w_rd_dur;
                        r_tone_en     <= (w_rd_period != '0);
                        r_note_start  <= 1'b1;
                        r_state       <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    // A pause that coincides with a sample swallows that sample.
                    if (i_play_pause) begin
                        r_state   <= ST_PAUSE;
                        r_tone_en <= 1'b0;
                    end else if (i_next_sample) begin
                        if (r_dur_cnt == DUR_W'(1)) begin
                            r_dur_cnt <= '0;
                            r_state   <= ST_LOAD;
                        end else if (r_dur_cnt != '0) begin
                            r_dur_cnt <= r_dur_cnt - 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (i_play_pause) begin
                        r_state   <= ST_PLAY;
                        r_tone_en <= (r_half_period != '0);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_to_idle) begin
                r_state       <= ST_IDLE;
                r_playing     <= 1'b0;
                r_tone_en     <= 1'b0;
                r_half_period <= '0;
                r_dur_cnt     <= '0;
                r_note_start  <= 1'b0;
            end
        end
    end

    assign o_half_period = r_half_period;
    assign o_tone_en     = r_tone_en;
    assign o_note_idx    = r_note_idx;
    assign o_note_start  = r_note_start;
    assign o_playing     = r_playing;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: one looping instance and one
// non-looping instance sharing the clock, table writes and sample strobe.
// Observed vector layout: {playing, tone_en, note_start, note_idx[3:0], half_period[11:0]}.
module tb_tone_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ns = 1'b0;
    logic        stop = 1'b0;
    logic        pp1 = 1'b0;
    logic        pp2 = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [11:0] wr_period = '0;
    logic [19:0] wr_dur = '0;

    logic [11:0] hp1, hp2;
    logic        te1, te2, st1, st2, pl1, pl2;
    logic [3:0]  idx1, idx2;

    wire [18:0] obs1 = {pl1, te1, st1, idx1, hp1};
    wire [18:0] obs2 = {pl2, te2, st2, idx2, hp2};

    logic [18:0] exp;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tone_sequencer #(.LOOP(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_next_sample(ns), .i_play_pause(pp1), .i_stop(stop),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_period(wr_period), .i_wr_dur(wr_dur),
        .o_half_period(hp1), .o_tone_en(te1), .o_note_idx(idx1), .o_note_start(st1),
        .o_playing(pl1)
    );

    tone_sequencer #(.LOOP(0)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_next_sample(ns), .i_play_pause(pp2), .i_stop(stop),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_period(wr_period), .i_wr_dur(wr_dur),
        .o_half_period(hp2), .o_tone_en(te2), .o_note_idx(idx2), .o_note_start(st2),
        .o_playing(pl2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One sample strobe followed by one quiet cycle.
    task automatic samples(input int n);
        for (int k = 0; k < n; k++) begin
            ns = 1'b1; tick(); ns = 1'b0; tick();
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [11:0] p, input logic [19:0] d);
        wr_en = 1'b1; wr_addr = a; wr_period = p; wr_dur = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    task automatic start1();
        pp1 = 1'b1; tick(); pp1 = 1'b0; tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        n_cmp++; if (obs1 !== 19'd0) begin n_err++; $display("FAIL reset_dut1: got %h want %h", obs1, 19'd0); end
        n_cmp++; if (obs2 !== 19'd0) begin n_err++; $display("FAIL reset_dut2: got %h want %h", obs2, 19'd0); end
    endtask

    task automatic test_loop();
        wr(4'd0, 12'd139, 20'd4); wr(4'd1, 12'd0, 20'd2); wr(4'd2, 12'd100, 20'd3); wr(4'd3, 12'd55, 20'd0);
        pp1 = 1'b1; tick(); pp1 = 1'b0;
        exp = {1'b1, 1'b0, 1'b0, 4'd0, 12'd0};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t1_load_cycle: got %h want %h", obs1, exp); end
        tick();
        exp = {1'b1, 1'b1, 1'b1, 4'd0, 12'd139};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t1_first_note: got %h want %h", obs1, exp); end
        samples(3);
        exp = {1'b1, 1'b1, 1'b0, 4'd0, 12'd139};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t1_idx0_hold: got %h want %h", obs1, exp); end
        samples(1);
        exp = {1'b1, 1'b0, 1'b1, 4'd1, 12'd0};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t1_rest_note: got %h want %h", obs1, exp); end
        samples(2);
        exp = {1'b1, 1'b1, 1'b1, 4'd2, 12'd100};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t1_idx2: got %h want %h", obs1, exp); end
        samples(3);
        exp = {1'b1, 1'b1, 1'b0, 4'd0, 12'd100};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t1_marker_wrap: got %h want %h", obs1, exp); end
        tick();
        exp = {1'b1, 1'b1, 1'b1, 4'd0, 12'd139};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t1_restart: got %h want %h", obs1, exp); end
        n_cmp++; if (obs2 !== 19'd0) begin n_err++; $display("FAIL t1_dut2_idle: got %h want %h", obs2, 19'd0); end
    endtask

    task automatic test_noloop();
        do_stop();
        n_cmp++; if (obs1 !== 19'd0) begin n_err++; $display("FAIL t2_stop_dut1: got %h want %h", obs1, 19'd0); end
        pp2 = 1'b1; tick(); pp2 = 1'b0; tick();
        exp = {1'b1, 1'b1, 1'b1, 4'd0, 12'd139};
        n_cmp++; if (obs2 !== exp) begin n_err++; $display("FAIL t2_first_note: got %h want %h", obs2, exp); end
        samples(4);
        exp = {1'b1, 1'b0, 1'b1, 4'd1, 12'd0};
        n_cmp++; if (obs2 !== exp) begin n_err++; $display("FAIL t2_rest_note: got %h want %h", obs2, exp); end
        samples(2);
        exp = {1'b1, 1'b1, 1'b1, 4'd2, 12'd100};
        n_cmp++; if (obs2 !== exp) begin n_err++; $display("FAIL t2_idx2: got %h want %h", obs2, exp); end
        samples(2);
        exp = {1'b1, 1'b1, 1'b0, 4'd2, 12'd100};
        n_cmp++; if (obs2 !== exp) begin n_err++; $display("FAIL t2_idx2_hold: got %h want %h", obs2, exp); end
        samples(1);
        n_cmp++; if (obs2 !== 19'd0) begin n_err++; $display("FAIL t2_end_idle: got %h want %h", obs2, 19'd0); end
        n_cmp++; if (obs1 !== 19'd0) begin n_err++; $display("FAIL t2_dut1_idle: got %h want %h", obs1, 19'd0); end
    endtask

    task automatic test_pause();
        wr(4'd0, 12'd50, 20'd5); wr(4'd1, 12'd60, 20'd1); wr(4'd2, 12'd0, 20'd0);
        start1();
        exp = {1'b1, 1'b1, 1'b1, 4'd0, 12'd50};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t3_start: got %h want %h", obs1, exp); end
        samples(2);
        pp1 = 1'b1; tick(); pp1 = 1'b0;
        exp = {1'b1, 1'b0, 1'b0, 4'd0, 12'd50};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t3_paused: got %h want %h", obs1, exp); end
        samples(10);
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t3_frozen: got %h want %h", obs1, exp); end
        pp1 = 1'b1; tick(); pp1 = 1'b0;
        exp = {1'b1, 1'b1, 1'b0, 4'd0, 12'd50};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t3_resumed: got %h want %h", obs1, exp); end
        samples(2);
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t3_two_more: got %h want %h", obs1, exp); end
        samples(1);
        exp = {1'b1, 1'b1, 1'b1, 4'd1, 12'd60};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t3_next_note: got %h want %h", obs1, exp); end
    endtask

    task automatic test_pause_last_sample();
        ns = 1'b1; pp1 = 1'b1; tick(); ns = 1'b0; pp1 = 1'b0;
        exp = {1'b1, 1'b0, 1'b0, 4'd1, 12'd60};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t4_pause_wins: got %h want %h", obs1, exp); end
        tick();
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t4_still_paused: got %h want %h", obs1, exp); end
        pp1 = 1'b1; tick(); pp1 = 1'b0;
        exp = {1'b1, 1'b1, 1'b0, 4'd1, 12'd60};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t4_resumed: got %h want %h", obs1, exp); end
        samples(1);
        exp = {1'b1, 1'b1, 1'b0, 4'd0, 12'd60};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t4_sample_kept: got %h want %h", obs1, exp); end
        tick();
        exp = {1'b1, 1'b1, 1'b1, 4'd0, 12'd50};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t4_wrapped: got %h want %h", obs1, exp); end
    endtask

    task automatic test_stop();
        samples(2);
        do_stop();
        n_cmp++; if (obs1 !== 19'd0) begin n_err++; $display("FAIL t5_stopped: got %h want %h", obs1, 19'd0); end
        start1();
        exp = {1'b1, 1'b1, 1'b1, 4'd0, 12'd50};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t5_restart: got %h want %h", obs1, exp); end
        samples(4);
        exp = {1'b1, 1'b1, 1'b0, 4'd0, 12'd50};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t5_reloaded: got %h want %h", obs1, exp); end
        samples(1);
        exp = {1'b1, 1'b1, 1'b1, 4'd1, 12'd60};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t5_next_note: got %h want %h", obs1, exp); end
    endtask

    task automatic test_collision();
        wr(4'd0, 12'd70, 20'd1); wr(4'd1, 12'd80, 20'd2); wr(4'd2, 12'd0, 20'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++; if (obs1 !== 19'd0) begin n_err++; $display("FAIL t6_reset: got %h want %h", obs1, 19'd0); end
        start1();
        exp = {1'b1, 1'b1, 1'b1, 4'd0, 12'd70};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t6_table_kept: got %h want %h", obs1, exp); end
        ns = 1'b1; tick(); ns = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd1; wr_period = 12'd200; wr_dur = 20'd7;
        tick();
        wr_en = 1'b0;
        exp = {1'b1, 1'b1, 1'b1, 4'd1, 12'd80};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t6_old_value: got %h want %h", obs1, exp); end
        samples(1);
        exp = {1'b1, 1'b1, 1'b0, 4'd1, 12'd80};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t6_old_dur: got %h want %h", obs1, exp); end
        samples(1);
        tick();
        exp = {1'b1, 1'b1, 1'b1, 4'd0, 12'd70};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t6_second_pass: got %h want %h", obs1, exp); end
        samples(1);
        exp = {1'b1, 1'b1, 1'b1, 4'd1, 12'd200};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t6_new_value: got %h want %h", obs1, exp); end
        samples(6);
        exp = {1'b1, 1'b1, 1'b0, 4'd1, 12'd200};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL t6_new_dur: got %h want %h", obs1, exp); end
    endtask

    task automatic test_wrap();
        do_stop();
        for (int i = 0; i < 16; i++) wr(4'(i), 12'(i + 1), 20'd1);
        pp1 = 1'b1; pp2 = 1'b1; tick(); pp1 = 1'b0; pp2 = 1'b0; tick();
        exp = {1'b1, 1'b1, 1'b1, 4'd0, 12'd1};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL wrap_start: got %h want %h", obs1, exp); end
        for (int i = 1; i < 16; i++) begin
            samples(1);
            exp = {1'b1, 1'b1, 1'b1, 4'(i), 12'(i + 1)};
            n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL wrap_idx%0d: got %h want %h", i, obs1, exp); end
        end
        n_cmp++; if (obs2 !== exp) begin n_err++; $display("FAIL wrap_dut2_last: got %h want %h", obs2, exp); end
        samples(1);
        exp = {1'b1, 1'b1, 1'b1, 4'd0, 12'd1};
        n_cmp++; if (obs1 !== exp) begin n_err++; $display("FAIL wrap_loop_to_0: got %h want %h", obs1, exp); end
        n_cmp++; if (obs2 !== 19'd0) begin n_err++; $display("FAIL wrap_noloop_idle: got %h want %h", obs2, 19'd0); end
    endtask

    initial begin
        test_reset();
        test_loop();
        test_noloop();
        test_pause();
        test_pause_last_sample();
        test_stop();
        test_collision();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
